// File: rtl/word_scrambler.sv
// Letter engine: fetches a target word from ROM, scrambles a copy with
// LFSR-driven swaps, then lets the player swap letters back into place.
module word_scrambler #(
  parameter int         SCRAM_SWAPS = 8,
  parameter int         MAX_ROUNDS  = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scram_pls,
  input  logic        flip_pls,
  input  logic [2:0]  lett_num,
  input  logic [2:0]  ind1,
  input  logic [2:0]  ind2,
  output logic [5:0]  rom_addr,
  input  logic [29:0] rom_data,
  output logic [29:0] cur_word,
  output logic        busy,
  output logic        is_correct
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SCRAM,
    CHECK,
    READY
  } state_t;

  state_t      state;
  logic [7:0]  lfsr;
  logic [2:0]  len;
  logic [29:0] target;
  logic [3:0]  swaps;
  logic [3:0]  rounds;

  logic        lfsrFb;
  logic        lastSwap;
  logic        again;
  logic        flipOk;
  logic        match;
  logic [2:0]  swA;
  logic [2:0]  swB;
  logic [1:0]  lenOff;

  function automatic logic [2:0] reduce(
    input logic [2:0] r,
    input logic [2:0] n
  );
    return (r >= n) ? r - n : r;
  endfunction

  function automatic logic [29:0] swapLet(
    input logic [29:0] w,
    input logic [2:0]  a,
    input logic [2:0]  b
  );
    logic [29:0] s;
    s = w;
    s[5*int'(a) +: 5] = w[5*int'(b) +: 5];
    s[5*int'(b) +: 5] = w[5*int'(a) +: 5];
    return s;
  endfunction

  assign lfsrFb   = lfsr[7] ^ lfsr[5]
                  ^ lfsr[4] ^ lfsr[3];
  assign swA      = reduce(lfsr[2:0], len);
  assign swB      = reduce(lfsr[5:3], len);
  assign lenOff   = 2'(len - 3'd4);
  assign match    = (cur_word == target);
  assign lastSwap = (swaps == 4'(SCRAM_SWAPS - 1));
  assign again    = match
                  && (int'(rounds) + 1 < MAX_ROUNDS);
  // flips touch only live letters and need two distinct slots
  assign flipOk   = flip_pls
                  && (ind1 < len)
                  && (ind2 < len)
                  && (ind1 != ind2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      len        <= 3'd4;
      rom_addr   <= '0;
      cur_word   <= '0;
      target     <= '0;
      swaps      <= '0;
      rounds     <= '0;
      busy       <= 1'b0;
      is_correct <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsrFb};
      if (scram_pls) begin
        len <= (lett_num >= 3'd4 && lett_num <= 3'd6)
             ? lett_num : 3'd4;
        state      <= FETCH;
        busy       <= 1'b1;
        is_correct <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            busy       <= 1'b0;
            is_correct <= 1'b0;
          end
          FETCH: begin
            rom_addr <= {lenOff, lfsr[3:0]};
            rounds   <= '0;
            state    <= LOAD;
          end
          LOAD: begin
            target   <= rom_data;
            cur_word <= rom_data;
            swaps    <= '0;
            state    <= SCRAM;
          end
          SCRAM: begin
            cur_word <= swapLet(cur_word, swA, swB);
            swaps    <= swaps + 4'd1;
            if (lastSwap) state <= CHECK;
          end
          CHECK: begin
            // a round that left the word intact is retried
            if (again) begin
              rounds <= rounds + 4'd1;
              swaps  <= '0;
              state  <= SCRAM;
            end else begin
              state      <= READY;
              busy       <= 1'b0;
              is_correct <= match;
            end
          end
          READY: begin
            is_correct <= match;
            if (flipOk)
              cur_word <= swapLet(cur_word, ind1, ind2);
          end
          default: begin
            state      <= IDLE;
            busy       <= 1'b0;
            is_correct <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_scrambler.sv
// Randomised bench for word_scrambler, checked against a
// letter-array model of the scramble and flip rules.
module tb_word_scrambler;

  localparam int         SWAPS = 8;
  localparam int         MAXR  = 3;
  localparam logic [7:0] SEED  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scram_pls = 1'b0;
  logic        flip_pls = 1'b0;
  logic [2:0]  lett_num = '0;
  logic [2:0]  ind1 = '0;
  logic [2:0]  ind2 = '0;
  logic [5:0]  rom_addr;
  logic [29:0] rom_data = '0;
  logic [29:0] cur_word;
  logic        busy;
  logic        is_correct;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  mLfsr;
  logic [29:0] mTgt;
  logic [29:0] mWord;
  int          mLen;

  word_scrambler #(
    .SCRAM_SWAPS(SWAPS),
    .MAX_ROUNDS(MAXR),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scram_pls(scram_pls),
    .flip_pls(flip_pls),
    .lett_num(lett_num),
    .ind1(ind1),
    .ind2(ind2),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .cur_word(cur_word),
    .busy(busy),
    .is_correct(is_correct)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nx(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always @(posedge clk) begin
    if (!rst) mLfsr <= SEED;
    else      mLfsr <= nx(mLfsr);
  end

  function automatic int red(input int r, input int n);
    return (r >= n) ? r - n : r;
  endfunction

  function automatic int effLen(input int ln);
    return (ln >= 4 && ln <= 6) ? ln : 4;
  endfunction

  function automatic logic [29:0] pack(input int lt[6]);
    logic [29:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) w[5*i +: 5] = 5'(lt[i]);
    return w;
  endfunction

  // l1 is the LFSR value during the first cycle after the request
  function automatic logic [29:0] scrModel(
    input  logic [29:0] rom,
    input  int          n,
    input  logic [7:0]  l1,
    output int          rnds
  );
    int lt[6];
    int a, b, t;
    logic [7:0] l;
    for (int i = 0; i < 6; i++) lt[i] = int'(rom[5*i +: 5]);
    l = nx(nx(l1));
    rnds = 0;
    for (int r = 0; r < MAXR; r++) begin
      rnds = r + 1;
      for (int k = 0; k < SWAPS; k++) begin
        a = red(int'(l[2:0]), n);
        b = red(int'(l[5:3]), n);
        t = lt[a]; lt[a] = lt[b]; lt[b] = t;
        l = nx(l);
      end
      l = nx(l);
      if (pack(lt) != rom) break;
    end
    return pack(lt);
  endfunction

  function automatic logic [29:0] genWord(input int n);
    int lt[6];
    int v;
    bit dup;
    for (int i = 0; i < 6; i++) lt[i] = 0;
    for (int i = 0; i < n; i++) begin
      do begin
        v = int'($urandom_range(31, 1));
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (lt[j] == v) dup = 1'b1;
      end while (dup);
      lt[i] = v;
    end
    return pack(lt);
  endfunction

  task automatic startScram(
    input  logic [2:0]  ln,
    input  logic [29:0] rom,
    output logic [7:0]  l1
  );
    lett_num  = ln;
    rom_data  = rom;
    scram_pls = 1'b1;
    @(negedge clk);
    scram_pls = 1'b0;
    l1   = mLfsr;
    mLen = effLen(int'(ln));
    mTgt = rom;
  endtask

  task automatic flip(input int a, input int b);
    ind1     = 3'(a);
    ind2     = 3'(b);
    flip_pls = 1'b1;
    @(negedge clk);
    flip_pls = 1'b0;
  endtask

  task automatic waitReady(input int c0, output int cyc);
    cyc = c0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || is_correct !== 1'b0
        || cur_word !== '0 || rom_addr !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b ok=%b word=%h addr=%h want all 0",
               busy, is_correct, cur_word, rom_addr);
    end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || is_correct !== 1'b0
          || cur_word !== '0 || rom_addr !== '0) begin
        bad++;
        $display("FAIL idle_hold c%0d: busy=%b ok=%b word=%h addr=%h want 0",
                 c, busy, is_correct, cur_word, rom_addr);
      end
    end
  endtask

  task automatic test_scramble;
    logic [7:0]  l1;
    logic [29:0] rom;
    int          r;
    rom = genWord(5);
    startScram(3'd5, rom, l1);
    mWord = scrModel(rom, 5, l1, r);
    for (int c = 1; c <= 2 + r * (SWAPS + 1); c++) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_c%0d: got %b want 1", c, busy);
      end
      if (c == 2) begin
        total++;
        if (rom_addr !== {2'b01, l1[3:0]}) begin
          bad++;
          $display("FAIL rom_addr5: got %h want %h",
                   rom_addr, {2'b01, l1[3:0]});
        end
      end
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_c%0d: busy=%b want 0", 3 + r * 9, busy);
    end
    total++;
    if (cur_word !== mWord || cur_word[29:25] !== 5'd0) begin
      bad++;
      $display("FAIL scram5_word: got %h want %h", cur_word, mWord);
    end
    total++;
    if (is_correct !== (mWord == rom)) begin
      bad++;
      $display("FAIL scram5_ok: got %b want %b", is_correct, mWord == rom);
    end
  endtask

  task automatic test_solve;
    int lt[6];
    int tg[6];
    int jj, t;
    logic [29:0] prev;
    for (int i = 0; i < 6; i++) begin
      lt[i] = int'(mWord[5*i +: 5]);
      tg[i] = int'(mTgt[5*i +: 5]);
    end
    for (int i = 0; i < mLen; i++) begin
      if (lt[i] != tg[i]) begin
        jj = i;
        for (int j = mLen - 1; j > i; j--) if (lt[j] == tg[i]) jj = j;
        prev = pack(lt);
        t = lt[i]; lt[i] = lt[jj]; lt[jj] = t;
        flip(i, jj);
        total++;
        if (cur_word !== pack(lt) || is_correct !== (prev == mTgt)) begin
          bad++;
          $display("FAIL solve_flip %0d,%0d: word=%h ok=%b want %h ok=%b",
                   i, jj, cur_word, is_correct, pack(lt), prev == mTgt);
        end
        @(negedge clk);
        total++;
        if (is_correct !== (pack(lt) == mTgt)) begin
          bad++;
          $display("FAIL solve_ok %0d: got %b want %b",
                   i, is_correct, pack(lt) == mTgt);
        end
      end
    end
    total++;
    if (cur_word !== mTgt || is_correct !== 1'b1) begin
      bad++;
      $display("FAIL solved: word=%h ok=%b want %h ok=1",
               cur_word, is_correct, mTgt);
    end
    prev = pack(lt);
    t = lt[0]; lt[0] = lt[1]; lt[1] = t;
    flip(0, 1);
    total++;
    if (cur_word !== pack(lt) || is_correct !== (prev == mTgt)) begin
      bad++;
      $display("FAIL extra_flip: word=%h ok=%b want %h ok=%b",
               cur_word, is_correct, pack(lt), prev == mTgt);
    end
    @(negedge clk);
    total++;
    if (is_correct !== (pack(lt) == mTgt)) begin
      bad++;
      $display("FAIL extra_drop: got %b want %b",
               is_correct, pack(lt) == mTgt);
    end
    mWord = pack(lt);
  endtask

  task automatic test_invalid;
    logic [7:0]  l1;
    logic [29:0] rom;
    int          r, cyc;
    logic        expOk;
    int pa[3] = '{5, 2, 3};
    int pb[3] = '{0, 2, 4};
    rom = genWord(4);
    startScram(3'd4, rom, l1);
    mWord = scrModel(rom, 4, l1, r);
    flip(0, 1);
    flip(1, 2);
    flip(2, 3);
    waitReady(4, cyc);
    total++;
    if (cyc !== 3 + r * (SWAPS + 1) || cur_word !== mWord) begin
      bad++;
      $display("FAIL busy_flip: cyc=%0d word=%h want cyc=%0d word=%h",
               cyc, cur_word, 3 + r * (SWAPS + 1), mWord);
    end
    expOk = (mWord == rom);
    for (int k = 0; k < 3; k++) begin
      flip(pa[k], pb[k]);
      @(negedge clk);
      total++;
      if (cur_word !== mWord || is_correct !== expOk) begin
        bad++;
        $display("FAIL bad_flip %0d,%0d: word=%h ok=%b want %h ok=%b",
                 pa[k], pb[k], cur_word, is_correct, mWord, expOk);
      end
    end
  endtask

  task automatic test_identical;
    logic [7:0]  l1;
    logic [29:0] rom;
    int          r, cyc;
    rom = 30'h0108421;
    startScram(3'd4, rom, l1);
    mWord = scrModel(rom, 4, l1, r);
    waitReady(1, cyc);
    total++;
    if (cyc !== 3 + r * (SWAPS + 1) || r !== MAXR) begin
      bad++;
      $display("FAIL ident_lat: ready c%0d want c%0d",
               cyc, 3 + MAXR * (SWAPS + 1));
    end
    total++;
    if (cur_word !== rom || is_correct !== 1'b1) begin
      bad++;
      $display("FAIL ident_word: word=%h ok=%b want %h ok=1",
               cur_word, is_correct, rom);
    end
  endtask

  task automatic test_random;
    logic [7:0]  l1;
    logic [29:0] rom;
    logic [2:0]  ln;
    int          n, r, cyc;
    for (int it = 0; it < 6; it++) begin
      ln  = 3'($urandom_range(7, 0));
      n   = effLen(int'(ln));
      rom = genWord(n);
      startScram(ln, rom, l1);
      mWord = scrModel(rom, n, l1, r);
      @(negedge clk);
      total++;
      if (rom_addr !== {2'(n - 4), l1[3:0]}) begin
        bad++;
        $display("FAIL rand_addr ln=%0d: got %h want %h",
                 ln, rom_addr, {2'(n - 4), l1[3:0]});
      end
      waitReady(2, cyc);
      total++;
      if (cyc !== 3 + r * (SWAPS + 1) || cur_word !== mWord
          || is_correct !== (mWord == rom)) begin
        bad++;
        $display("FAIL rand_word ln=%0d: c%0d %h ok=%b want c%0d %h ok=%b",
                 ln, cyc, cur_word, is_correct,
                 3 + r * (SWAPS + 1), mWord, mWord == rom);
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
  endtask

  task automatic test_restart;
    logic [7:0]  l1;
    logic [29:0] rom;
    logic [29:0] prev;
    int          r, cyc;
    startScram(3'd4, genWord(4), l1);
    repeat (5) @(negedge clk);
    rom = genWord(6);
    startScram(3'd6, rom, l1);
    mWord = scrModel(rom, 6, l1, r);
    total++;
    if (busy !== 1'b1 || is_correct !== 1'b0) begin
      bad++;
      $display("FAIL restart_busy: busy=%b ok=%b want 1/0", busy, is_correct);
    end
    @(negedge clk);
    total++;
    if (rom_addr !== {2'b10, l1[3:0]}) begin
      bad++;
      $display("FAIL restart_addr: got %h want %h",
               rom_addr, {2'b10, l1[3:0]});
    end
    waitReady(2, cyc);
    total++;
    if (cyc !== 3 + r * (SWAPS + 1) || cur_word !== mWord) begin
      bad++;
      $display("FAIL restart_word: c%0d %h want c%0d %h",
               cyc, cur_word, 3 + r * (SWAPS + 1), mWord);
    end
    prev = mWord;
    ind1 = 3'd0;
    ind2 = 3'd1;
    flip_pls = 1'b1;
    startScram(3'd6, rom, l1);
    flip_pls = 1'b0;
    total++;
    if (cur_word !== prev || busy !== 1'b1 || is_correct !== 1'b0) begin
      bad++;
      $display("FAIL scram_flip: word=%h busy=%b ok=%b want %h 1 0",
               cur_word, busy, is_correct, prev);
    end
    mWord = scrModel(rom, 6, l1, r);
    waitReady(1, cyc);
    total++;
    if (cyc !== 3 + r * (SWAPS + 1) || cur_word !== mWord) begin
      bad++;
      $display("FAIL scram_flip_word: c%0d %h want c%0d %h",
               cyc, cur_word, 3 + r * (SWAPS + 1), mWord);
    end
    startScram(3'd5, genWord(5), l1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || is_correct !== 1'b0
        || cur_word !== '0 || rom_addr !== '0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b ok=%b word=%h addr=%h want 0",
               busy, is_correct, cur_word, rom_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_scramble;
    test_solve;
    test_invalid;
    test_identical;
    test_random;
    test_restart;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
